ret_addr_stack: RTL

RET_ADDR_STACK -- requirements
Module: ret_addr_stack

---
 rtl/soc_pkg.sv | 14 +
 rtl/stack_ram.sv | 25 ++
 rtl/ret_addr_stack.sv | 117 +++++++++++
 3 files changed

// File: rtl/soc_pkg.sv
// Shared definitions for the return-address stack: default address width,
// initial stack pointer and the pop FSM state type.
package soc_pkg;

  localparam int         AW  = 19;
  localparam logic [7:0] ISP = 8'h38;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/stack_ram.sv
// Single-port synchronous RAM with read-first behaviour: a write in the same
// cycle as a read returns the old contents of the addressed word.
module stack_ram #(
  parameter int AW    = 19,
  parameter int DEPTH = 56,
  parameter int RAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic           clk,
  input  logic           we,
  input  logic [RAW-1:0] addr,
  input  logic [AW-1:0]  wdata,
  output logic [AW-1:0]  rdata
);

  // Contents are never reset; they only start out zeroed at power-up.
  logic [AW-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    rdata <= mem[addr];
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/ret_addr_stack.sv
// Return-address stack: a downward-growing call stack held in a single-port
// RAM, with a pop FSM that delivers registered responses over valid/ack.
module ret_addr_stack #(
  parameter int         AW    = soc_pkg::AW,
  parameter logic [7:0] ISP   = soc_pkg::ISP,
  parameter int         DEPTH = int'(ISP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          call,
  input  logic [AW-1:0] call_addr,
  input  logic          ret,
  input  logic          ret_ack,
  input  logic          clr_err,
  output logic          ret_valid,
  output logic [AW-1:0] ret_addr,
  output logic          ret_err,
  output logic [7:0]    sp,
  output logic          busy,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          underflow
);

  import soc_pkg::*;

  localparam int         RAW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] BASE = ISP - 8'(DEPTH);

  state_t        state;
  logic          pend_err;
  logic          pop_req;
  logic          do_pop;
  logic          do_push;
  logic          do_swap;
  logic          ovf_evt;
  logic          udf_evt;
  logic [7:0]    slot;
  logic [RAW-1:0] ram_addr;
  logic [AW-1:0] ram_rdata;

  assign full  = (sp == BASE);
  assign empty = (sp == ISP);
  assign busy  = (state != IDLE);

  // A simultaneous call and ret on a non-empty stack becomes a swap of the
  // top slot: the read-first RAM returns the old top while the new one lands.
  assign pop_req = ret && (state == IDLE);
  assign do_pop  = pop_req && !empty;
  assign do_swap = do_pop && call;
  assign do_push = call && !full && !do_pop;
  assign ovf_evt = call && full && !do_pop;
  assign udf_evt = pop_req && empty;

  assign slot     = do_push ? (sp - 8'd1) : sp;
  assign ram_addr = RAW'(slot - BASE);

  stack_ram #(
    .AW    (AW),
    .DEPTH (DEPTH),
    .RAW   (RAW)
  ) u_ram (
    .clk   (clk),
    .we    (do_push || do_swap),
    .addr  (ram_addr),
    .wdata (call_addr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp        <= ISP;
      state     <= IDLE;
      pend_err  <= 1'b0;
      ret_valid <= 1'b0;
      ret_addr  <= '0;
      ret_err   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) begin
        sp <= sp - 8'd1;
      end else if (do_pop && !call) begin
        sp <= sp + 8'd1;
      end

      overflow  <= ovf_evt || (overflow && !clr_err);
      underflow <= udf_evt || (underflow && !clr_err);

      // The RAM word read during the pop edge is only available one cycle
      // later, hence the READ state before the response is registered.
      case (state)
        IDLE: begin
          if (ret) begin
            pend_err <= empty;
            state    <= READ;
          end
        end
        READ: begin
          ret_addr  <= pend_err ? '0 : ram_rdata;
          ret_err   <= pend_err;
          ret_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (ret_ack) begin
            ret_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
